oka_409bit: RTL and testbench
=============================

# oka_409bit

Registered 409×409-bit carry-less (GF(2)[x]) polynomial multiplier built on the overlap-free Karatsuba (OKA) decomposition. Used as the field-multiplication datapath for binary-field ECC (B-409/K-409 class). It produces the unreduced 817-bit product; modular reduction is done downstream. One pipeline register sits on the output, so the block is a single-cycle-latency, fully pipelined unit.

## Interface
- Parameters: none; widths are fixed by package constants `N = 409` and `Y_W = 2*N-1 = 817`.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  qualifies `a`/`b` in the current cycle.
- a  input  409  operand polynomial; bit i is the coefficient of x^i.
- b  input  409  operand polynomial; same bit ordering.
- out_valid  output  1  `y` holds the product of operands accepted one cycle earlier.
- y  output  817  product polynomial a(x)·b(x) over GF(2); bit k is the coefficient of x^k.

## Operation
- Arithmetic is carry-less: partial products are ANDed and accumulated by XOR. There are no carries and no reduction.
- y[k] = XOR over all i+j=k of (a[i] & b[j]), for 0 ≤ k ≤ 816. Bit 816 = a[408] & b[408].
- Top-level decomposition:
  - Split each operand into low half L (bits 0..204, 205 bits) and high half H (bits 205..408, 204 bits, zero-extended to 205).
  - Compute P0 = aL·bL, P2 = aH·bH and P1 = (aL^aH)·(bL^bH), each 409 bits.
  - Combine as y = P0 ^ ((P0^P1^P2) << 205) ^ (P2 << 410), truncated to 817 bits.
- Overlap-free form: the middle term is formed by splitting P0 and P2 into 205-bit segments and XOR-combining the segments without overlapping shifts. The result must be bit-identical to the formula above.
- Recursion: each sub-product uses the same Karatsuba split until the operand width is ≤ 26 bits. Below that width, use a schoolbook AND/XOR array.
- Odd widths always put the extra bit in the low half. Unused padding bits are zero and must not reach `y`.
- The combinational core has no internal state; `a` and `b` are not registered at the input.
- When in_valid=0, the output register holds its previous value. out_valid follows in_valid with a one-cycle delay.

## Timing
- Latency is 1 cycle. Operands sampled with in_valid=1 at edge t appear on `y`, with out_valid=1, after edge t.
- Throughput is one product per cycle with back-to-back in_valid. There is no backpressure and no stall.
- Reset: rst_n=0 asynchronously forces y=0 and out_valid=0 regardless of clk.
  - Reset asserted mid-stream discards the in-flight product.
  - The first edge after rst_n deasserts may capture a valid operand pair.
- The critical path is the full combinational Karatsuba tree plus the output register. Any extra pipelining is a later revision and must change this latency spec.

## Structure
- Shared package `oka_pkg` holds:
  - `N = 409`, `Y_W = 817`;
  - the leaf threshold `LEAF_W = 26`;
  - the halving helper constants: `ceil(w/2)` for the low-half width.
- Sub-module `gf2_kmul #(W)`: a parameterized, recursive, combinational carry-less Karatsuba multiplier producing a 2W-1-bit output. It self-instantiates three times until W ≤ LEAF_W, then switches to the schoolbook generate loop.
- Top `oka_409bit` instantiates `gf2_kmul #(409)` and adds the output/valid register with asynchronous reset.

## Test plan
- Reset: drive rst_n=0 with random `a`/`b` and in_valid=1 → y=0 and out_valid=0 immediately. Pulse rst_n low during back-to-back traffic → outputs clear asynchronously and the next accepted pair is correct.
- Small identities:
  - a=1, b=arbitrary → y = zero-extended b;
  - a=3, b=3 → y=5 (x²+1, no carry);
  - a=0 → y=0.
- Boundary bits:
  - a=b=1<<408 → only y[816]=1;
  - a=b=all-ones (409 bits) → y has exactly the even bit positions 0..816 set, all odd bits 0.
- Directed vector: a = 0xABABABABABABABABABAB and b = 0xFAAFD57EABF55FAAFD57, both zero-extended 80-bit values → y matches a bit-serial shift/XOR reference model, and y[816:159]=0.
- Streaming: 1000 random pairs with in_valid=1 every cycle, interleaved with in_valid=0 bubbles.
  - Each y matches the reference model exactly one cycle after acceptance.
  - During bubbles, y holds its value and out_valid=0.
- Half-boundary: set single bits at 204 and 205 in each operand, all four combinations → y has a single bit at the sum of the two indices. Run the same check on `gf2_kmul` at W = 25, 26, 27.

Source files
------------

// File: rtl/oka_pkg.sv
// rtl/oka_pkg.sv - shared widths and split helpers for the 409-bit OKA multiplier
//
// Purpose : constants used by the top-level multiplier and the recursive
//           carry-less Karatsuba core.
// Contents: N      - operand width (409)
//           Y_W    - unreduced product width (2*N-1 = 817)
//           LEAF_W - widest operand handled by the schoolbook array
//           low_w  - width of the low half when splitting a w-bit operand
//           high_w - width of the high half when splitting a w-bit operand
package oka_pkg;

    localparam int N      = 409;
    localparam int Y_W    = 2 * N - 1;
    localparam int LEAF_W = 26;

    // Odd widths place the extra bit in the low half, so the low half is
    // never narrower than the high half.
    function automatic int low_w(input int w);
        return (w + 1) / 2;
    endfunction

    function automatic int high_w(input int w);
        return w - low_w(w);
    endfunction

endpackage

// File: rtl/gf2_kmul.sv
// rtl/gf2_kmul.sv - recursive combinational carry-less Karatsuba multiplier
//
// Purpose : y_o = a_i(x) * b_i(x) over GF(2), unreduced, no internal state.
//           Operands wider than LEAF_W are split into a low half of
//           low_w(W) bits and a high half of high_w(W) bits, and three
//           narrower instances of this module compute the sub-products.
//           At or below LEAF_W a schoolbook AND/XOR array is used.
// Ports   : a_i [W-1:0]    operand, bit i is the coefficient of x^i
//           b_i [W-1:0]    operand, same ordering
//           y_o [2*W-2:0]  product, bit k is the coefficient of x^k
module gf2_kmul
    import oka_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    output logic [2*W-2:0] y_o
);

    if (W <= LEAF_W) begin : g_leaf

        always_comb begin
            y_o = '0;
            for (int i = 0; i < W; i++) begin
                for (int j = 0; j < W; j++) begin
                    y_o[i+j] = y_o[i+j] ^ (a_i[i] & b_i[j]);
                end
            end
        end

    end else begin : g_split

        localparam int LW  = low_w(W);
        localparam int HW  = high_w(W);
        // Width of the top output segment; equals the width of the part of
        // P2 that lies above its first LW bits.
        localparam int TW  = 2 * W - 1 - 3 * LW;

        logic [LW-1:0]     a_lo;
        logic [LW-1:0]     b_lo;
        logic [HW-1:0]     a_hi;
        logic [HW-1:0]     b_hi;
        logic [LW-1:0]     a_mid;
        logic [LW-1:0]     b_mid;

        logic [2*LW-2:0]   p0;
        logic [2*LW-2:0]   p1;
        logic [2*HW-2:0]   p2;

        // Each sub-product cut into an LW-bit low segment and the rest.
        logic [LW-1:0]     p0_lo;
        logic [LW-2:0]     p0_hi;
        logic [LW-1:0]     p1_lo;
        logic [LW-2:0]     p1_hi;
        logic [LW-1:0]     p2_lo;
        logic [TW-1:0]     p2_hi;

        logic [LW-1:0]     shared_t;
        logic [LW-1:0]     seg1;
        logic [LW-1:0]     seg2;

        assign a_lo  = a_i[LW-1:0];
        assign b_lo  = b_i[LW-1:0];
        assign a_hi  = a_i[W-1:LW];
        assign b_hi  = b_i[W-1:LW];

        // The high half is zero-extended to LW before forming the sums.
        assign a_mid = a_lo ^ LW'(a_hi);
        assign b_mid = b_lo ^ LW'(b_hi);

        gf2_kmul #(.W(LW)) u_p0 (.a_i(a_lo),  .b_i(b_lo),  .y_o(p0));
        gf2_kmul #(.W(LW)) u_p1 (.a_i(a_mid), .b_i(b_mid), .y_o(p1));
        gf2_kmul #(.W(HW)) u_p2 (.a_i(a_hi),  .b_i(b_hi),  .y_o(p2));

        assign p0_lo = p0[LW-1:0];
        assign p0_hi = p0[2*LW-2:LW];
        assign p1_lo = p1[LW-1:0];
        assign p1_hi = p1[2*LW-2:LW];
        assign p2_lo = p2[LW-1:0];
        assign p2_hi = p2[2*HW-2:LW];

        // Overlap-free combination: the product is four LW-bit segments
        //   seg0 = P0lo
        //   seg1 = P0lo ^ P1lo ^ P2lo ^ P0hi
        //   seg2 = P0hi ^ P1hi ^ P2hi ^ P2lo
        //   seg3 = P2hi
        // which expands P0 ^ ((P0^P1^P2) << LW) ^ (P2 << 2*LW) with no
        // overlapping shifted adds. P0hi ^ P2lo is shared by seg1 and seg2.
        assign shared_t = LW'(p0_hi) ^ p2_lo;
        assign seg1     = shared_t ^ p0_lo ^ p1_lo;
        assign seg2     = shared_t ^ LW'(p1_hi) ^ LW'(p2_hi);

        assign y_o = {p2_hi, seg2, seg1, p0_lo};

    end

endmodule

// File: rtl/oka_409bit.sv
// rtl/oka_409bit.sv - registered 409x409-bit carry-less OKA multiplier
//
// Purpose : unreduced GF(2)[x] product of two 409-bit polynomials with a
//           single output register (latency 1, one product per cycle).
// Ports   : clk        rising-edge clock
//           rst_n      asynchronous active-low reset, clears y and out_valid
//           in_valid   qualifies a/b this cycle
//           a, b       409-bit operands, bit i is the coefficient of x^i
//           out_valid  y holds the product of operands accepted last cycle
//           y          817-bit product, bit k is the coefficient of x^k
module oka_409bit
    import oka_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           out_valid,
    output logic [Y_W-1:0] y
);

    logic [Y_W-1:0] prod;
    logic [Y_W-1:0] y_d;
    logic [Y_W-1:0] y_q;
    logic           out_valid_q;

    gf2_kmul #(.W(N)) u_core (
        .a_i (a),
        .b_i (b),
        .y_o (prod)
    );

    // Bubbles leave the last product on y; only out_valid drops.
    assign y_d = in_valid ? prod : y_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            y_q         <= y_d;
            out_valid_q <= in_valid;
        end
    end

    assign y         = y_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_oka_409bit.sv
// tb/tb_oka_409bit.sv - self-checking bench for oka_409bit and gf2_kmul
module tb_oka_409bit;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [408:0] a;
    logic [408:0] b;
    logic         out_valid;
    logic [816:0] y;

    int errors = 0;
    int checks = 0;

    oka_409bit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .y         (y)
    );

    logic [24:0] k25_a, k25_b;
    logic [48:0] k25_y;
    logic [25:0] k26_a, k26_b;
    logic [50:0] k26_y;
    logic [26:0] k27_a, k27_b;
    logic [52:0] k27_y;

    gf2_kmul #(.W(25)) u_k25 (.a_i(k25_a), .b_i(k25_b), .y_o(k25_y));
    gf2_kmul #(.W(26)) u_k26 (.a_i(k26_a), .b_i(k26_b), .y_o(k26_y));
    gf2_kmul #(.W(27)) u_k27 (.a_i(k27_a), .b_i(k27_b), .y_o(k27_y));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [816:0] clmul(input logic [408:0] x, input logic [408:0] z);
        logic [816:0] acc;
        logic [816:0] zz;
        acc = '0;
        zz  = {408'b0, z};
        for (int i = 0; i < 409; i++) begin
            if (x[i]) acc = acc ^ zz;
            zz = zz << 1;
        end
        return acc;
    endfunction

    function automatic logic [408:0] rand409();
        logic [415:0] t;
        for (int k = 0; k < 13; k++) t[k*32 +: 32] = $urandom;
        return t[408:0];
    endfunction

    task automatic run_pair(input logic [408:0] ta, input logic [408:0] tb_v,
                            input logic [816:0] exp_y, input string name);
        @(negedge clk);
        a = ta; b = tb_v; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (y !== exp_y || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s: got v=%b y=%h exp v=1 y=%h", name, out_valid, y, exp_y);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; a = rand409(); b = rand409();
        #2;
        checks++;
        if (y !== '0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: got v=%b y=%h exp 0", out_valid, y);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (y !== '0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_held: got v=%b y=%h exp 0", out_valid, y);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_identities();
        logic [408:0] r;
        logic [816:0] e;
        r = rand409();
        run_pair(409'd1, r, {408'b0, r}, "one_times_b");
        run_pair(409'd3, 409'd3, 817'd5, "three_sq");
        run_pair(409'd0, rand409(), '0, "zero_times_b");
        e = '0; e[816] = 1'b1;
        run_pair(409'd1 << 408, 409'd1 << 408, e, "top_bit_sq");
        e = '0;
        for (int k = 0; k <= 816; k += 2) e[k] = 1'b1;
        run_pair({409{1'b1}}, {409{1'b1}}, e, "all_ones_sq");
    endtask

    task automatic test_directed();
        logic [408:0] da;
        logic [408:0] db;
        da = 409'(80'hABABABABABABABABABAB);
        db = 409'(80'hFAAFD57EABF55FAAFD57);
        run_pair(da, db, clmul(da, db), "directed_80bit");
        checks++;
        if (y[816:159] !== '0) begin
            errors++;
            $display("FAIL directed_upper_zero: got %h exp 0", y[816:159]);
        end
    endtask

    task automatic test_half_boundary();
        int idx [2];
        logic [816:0] e;
        idx[0] = 204; idx[1] = 205;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                e = '0; e[idx[i] + idx[j]] = 1'b1;
                run_pair(409'd1 << idx[i], 409'd1 << idx[j], e, $sformatf("half_%0d_%0d", idx[i], idx[j]));
            end
        end
    endtask

    task automatic test_kmul_widths();
        logic [48:0] e25;
        logic [50:0] e26;
        logic [52:0] e27;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                k25_a = 25'd1 << (12 + i); k25_b = 25'd1 << (12 + j);
                k26_a = 26'd1 << (12 + i); k26_b = 26'd1 << (12 + j);
                k27_a = 27'd1 << (13 + i); k27_b = 27'd1 << (13 + j);
                e25 = 49'd1 << (24 + i + j);
                e26 = 51'd1 << (24 + i + j);
                e27 = 53'd1 << (26 + i + j);
                #1;
                checks++;
                if (k25_y !== e25) begin
                    errors++;
                    $display("FAIL kmul25_%0d_%0d: got %h exp %h", i, j, k25_y, e25);
                end
                checks++;
                if (k26_y !== e26) begin
                    errors++;
                    $display("FAIL kmul26_%0d_%0d: got %h exp %h", i, j, k26_y, e26);
                end
                checks++;
                if (k27_y !== e27) begin
                    errors++;
                    $display("FAIL kmul27_%0d_%0d: got %h exp %h", i, j, k27_y, e27);
                end
            end
        end
        // Full-width odd split: all-ones squared gives only even bits.
        k27_a = '1; k27_b = '1;
        e27 = '0;
        for (int k = 0; k <= 52; k += 2) e27[k] = 1'b1;
        #1;
        checks++;
        if (k27_y !== e27) begin
            errors++;
            $display("FAIL kmul27_ones: got %h exp %h", k27_y, e27);
        end
    endtask

    task automatic test_back_to_back();
        int           sent;
        int           cyc;
        logic         pend_valid;
        logic [816:0] pend_exp;
        logic [816:0] held;
        logic [408:0] ra;
        logic [408:0] rb;
        logic         bubble;
        sent = 0; cyc = 0; pend_valid = 1'b0; pend_exp = '0; held = '0;
        while (sent < 1000 && cyc < 5000) begin
            @(negedge clk);
            if (cyc > 0) begin
                checks++;
                if (pend_valid) begin
                    if (y !== pend_exp || out_valid !== 1'b1) begin
                        errors++;
                        $display("FAIL stream_cyc%0d: got v=%b y=%h exp v=1 y=%h", cyc, out_valid, y, pend_exp);
                    end
                    held = pend_exp;
                end else if (y !== held || out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL bubble_cyc%0d: got v=%b y=%h exp v=0 y=%h", cyc, out_valid, y, held);
                end
            end
            ra = rand409(); rb = rand409();
            bubble = (cyc > 0) && ($urandom_range(0, 3) == 0);
            a = ra; b = rb;
            if (bubble) begin
                in_valid = 1'b0;
                pend_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                pend_valid = 1'b1;
                pend_exp = clmul(ra, rb);
                sent++;
            end
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (!pend_valid || y !== pend_exp || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL stream_last: got v=%b y=%h exp v=1 y=%h", out_valid, y, pend_exp);
        end
    endtask

    task automatic test_reset_midstream();
        logic [408:0] ra;
        logic [408:0] rb;
        logic [816:0] e;
        ra = rand409(); rb = rand409();
        e = clmul(ra, rb);
        @(negedge clk);
        a = ra; b = rb; in_valid = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (y !== e || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: got v=%b y=%h exp %h", out_valid, y, e);
        end
        a = rand409(); b = rand409();
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (y !== '0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_clear: got v=%b y=%h exp 0", out_valid, y);
        end
        @(negedge clk);
        rst_n = 1'b1;
        ra = rand409(); rb = rand409();
        a = ra; b = rb; in_valid = 1'b1;
        e = clmul(ra, rb);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (y !== e || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_pair: got v=%b y=%h exp %h", out_valid, y, e);
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0;
        k25_a = '0; k25_b = '0; k26_a = '0; k26_b = '0; k27_a = '0; k27_b = '0;
        test_reset();
        test_identities();
        test_directed();
        test_half_boundary();
        test_kmul_widths();
        test_back_to_back();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
